// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider: mode encoding,
// default sizing and the divisor clamp rule applied when a request is captured.
package clkdiv_pkg;

  localparam logic MODE_LIN = 1'b0;
  localparam logic MODE_POW = 1'b1;

  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 4;

  typedef struct packed {
    logic [31:0] div;
    logic        err;
  } clamp_t;

  // Maps a raw request onto a legal divisor; err marks a request that had to be changed.
  function automatic clamp_t clamp_div(input logic mode, input logic [31:0] value,
                                       input int cnt_w);
    clamp_t     r;
    logic [4:0] exp_v;
    exp_v = value[4:0];
    r.div = value;
    r.err = 1'b0;
    if (mode == MODE_LIN) begin
      if (value < 32'd2) begin
        r.div = 32'd2;
        r.err = 1'b1;
      end
    end else begin
      if (exp_v == 5'd0) begin
        r.div = 32'd2;
        r.err = 1'b1;
      end else if (int'(exp_v) > cnt_w - 1) begin
        r.div = 32'd1 << (cnt_w - 1);
        r.err = 1'b1;
      end else begin
        r.div = 32'd1 << exp_v;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/clkdiv_cfg_reg.sv
// Divisor configuration: captures and clamps load requests, holds one pending
// request and applies it when the phase counter is at a period boundary.
module clkdiv_cfg_reg
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             apply,
  input  logic             div_load,
  input  logic             div_mode,
  input  logic [CNT_W-1:0] div_value,
  output logic [CNT_W-1:0] cur_div,
  output logic             cfg_err,
  output logic             div_busy
);

  clamp_t           req;
  logic [CNT_W-1:0] pend_div;
  logic             pend_err;

  assign req = clamp_div(div_mode, 32'(div_value), CNT_W);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_div  <= CNT_W'(DEFAULT_DIV);
      cfg_err  <= 1'b0;
      div_busy <= 1'b0;
      // NOTE: the pending slot is reset too, so a stale request can never be
      // applied after reset even though div_busy already gates it.
      pend_div <= '0;
      pend_err <= 1'b0;
    end else begin
      // The old pending value is applied before a same-edge load replaces it.
      if (apply && div_busy) begin
        cur_div <= pend_div;
        cfg_err <= pend_err;
      end
      if (div_load) begin
        pend_div <= CNT_W'(req.div);
        pend_err <= req.err;
        div_busy <= 1'b1;
      end else if (apply) begin
        div_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider: phase counter and registered, glitch-free
// out_clk / out_tick, with divisor changes taking effect only at period start.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             enable,
  input  logic             div_mode,
  input  logic [CNT_W-1:0] div_value,
  input  logic             div_load,
  output logic             div_busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             cfg_err,
  output logic             out_clk,
  output logic             out_tick
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X = (CNT_W + 1)'(1);

  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_next;
  logic             running;
  logic [CNT_W:0]   half;
  logic             apply;

  // NOTE: phase_next gets a default before any condition, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    phase_next = '0;
    if (enable && running && (phase != cur_div - ONE))
      phase_next = phase + ONE;
  end

  // At phase_next==0 out_clk is high for every legal D, so the old divisor is
  // sufficient here; the new one governs from the following cycle on.
  assign half  = ({1'b0, cur_div} + ONE_X) >> 1;
  assign apply = !enable || (phase_next == '0);

  clkdiv_cfg_reg #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_cfg (
    .clk      (in_clk),
    .rst_n    (in_rst_n),
    .apply    (apply),
    .div_load (div_load),
    .div_mode (div_mode),
    .div_value(div_value),
    .cur_div  (cur_div),
    .cfg_err  (cfg_err),
    .div_busy (div_busy)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      phase    <= '0;
      running  <= 1'b0;
      out_clk  <= 1'b0;
      out_tick <= 1'b0;
    end else if (!enable) begin
      phase    <= '0;
      running  <= 1'b0;
      out_clk  <= 1'b0;
      out_tick <= 1'b0;
    end else begin
      phase    <= phase_next;
      running  <= 1'b1;
      out_clk  <= ({1'b0, phase_next} < half);
      out_tick <= (phase_next == '0);
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomised scoreboard bench for prog_clock_divider: a period-waveform model
// queues the expected outputs per edge and a monitor compares them.
module tb_prog_clock_divider;

  localparam int CNT_W = 16;

  logic             in_clk = 1'b0;
  logic             in_rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             div_mode = 1'b0;
  logic [CNT_W-1:0] div_value = '0;
  logic             div_load = 1'b0;
  logic             div_busy;
  logic [CNT_W-1:0] cur_div;
  logic             cfg_err;
  logic             out_clk;
  logic             out_tick;

  prog_clock_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .enable   (enable),
    .div_mode (div_mode),
    .div_value(div_value),
    .div_load (div_load),
    .div_busy (div_busy),
    .cur_div  (cur_div),
    .cfg_err  (cfg_err),
    .out_clk  (out_clk),
    .out_tick (out_tick)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    bit          clk;
    bit          tick;
    bit          busy;
    int unsigned div;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  bit          pat[$];
  int unsigned m_div;
  bit          m_err;
  bit          pend_valid;
  int unsigned pend_div;
  bit          pend_err;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference clamp written directly from the divisor rules.
  task automatic model_clamp(input bit mode, input int unsigned v,
                             output int unsigned d, output bit e);
    int unsigned x;
    if (!mode) begin
      if (v < 2) begin d = 2; e = 1; end
      else begin d = v; e = 0; end
    end else begin
      x = v % 32;
      if (x == 0)      begin d = 2;         e = 1; end
      else if (x > 15) begin d = 32768;     e = 1; end
      else             begin d = 1 << x;    e = 0; end
    end
  endtask

  task automatic model_reset();
    pat.delete();
    m_div      = 4;
    m_err      = 0;
    pend_valid = 0;
    pend_div   = 0;
    pend_err   = 0;
  endtask

  task automatic apply_pending();
    if (pend_valid) begin
      m_div      = pend_div;
      m_err      = pend_err;
      pend_valid = 0;
    end
  endtask

  // Drives one edge's inputs and queues the response expected after that edge.
  task automatic cycle(input bit en, input bit ld, input bit md, input int unsigned val);
    exp_t        e;
    int unsigned high;
    @(negedge in_clk);
    enable    = en;
    div_load  = ld;
    div_mode  = md;
    div_value = CNT_W'(val);
    e.tick = 0;
    if (!en) begin
      pat.delete();
      apply_pending();
      e.clk = 0;
    end else begin
      if (pat.size() == 0) begin
        apply_pending();
        high = m_div - m_div / 2;
        for (int i = 0; i < int'(m_div); i++) pat.push_back(i < int'(high));
        e.tick = 1;
      end
      e.clk = pat.pop_front();
    end
    if (ld) begin
      model_clamp(md, val & 32'hFFFF, pend_div, pend_err);
      pend_valid = 1;
    end
    e.busy = pend_valid;
    e.div  = m_div;
    e.err  = m_err;
    sb.push_back(e);
    last_exp = e;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge in_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_clk",  out_clk,  e.clk);
        check("out_tick", out_tick, e.tick);
        check("div_busy", div_busy, e.busy);
        check("cur_div",  cur_div,  e.div);
        check("cfg_err",  cfg_err,  e.err);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    int tries;
    model_reset();
    repeat (3) @(posedge in_clk);
    #2;
    check("rst_out_clk",  out_clk,  0);
    check("rst_out_tick", out_tick, 0);
    check("rst_busy",     div_busy, 0);
    check("rst_cur_div",  cur_div,  4);
    check("rst_cfg_err",  cfg_err,  0);
    @(negedge in_clk);
    in_rst_n = 1'b1;

    // Default divide-by-4 run
    repeat (12) cycle(1, 0, 0, 0);
    // Linear 5 loaded mid-period
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 5);
    repeat (14) cycle(1, 0, 0, 0);
    // Power 2^3, then an out-of-range exponent
    cycle(1, 1, 1, 3);
    repeat (20) cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 20);
    repeat (10) cycle(1, 0, 0, 0);
    // Linear 1 clamps to 2 (applied via enable drop), then 6 clears the error
    cycle(0, 1, 0, 1);
    repeat (8) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 6);
    repeat (14) cycle(1, 0, 0, 0);
    // Back-to-back loads: last one wins
    cycle(1, 1, 0, 7);
    cycle(1, 1, 0, 9);
    repeat (12) cycle(1, 0, 0, 0);
    // Load exactly on a wrap edge
    tries = 0;
    while (pat.size() != 0 && tries < 40) begin
      cycle(1, 0, 0, 0);
      tries++;
    end
    check("wrap_found", pat.size(), 0);
    cycle(1, 1, 0, 3);
    repeat (20) cycle(1, 0, 0, 0);
    // Enable dropped mid-period, then re-enabled
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    repeat (8) cycle(1, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      bit          en, ld, md;
      int unsigned val;
      en = ($urandom_range(0, 19) != 0);
      ld = ($urandom_range(0, 11) == 0);
      md = 1'($urandom_range(0, 1));
      if (md) val = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(0, 65535);
      else    val = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 12) : $urandom_range(0, 300);
      cycle(en, ld, md, val);
    end

    // Asynchronous reset in the middle of an out_clk high phase
    cycle(0, 1, 0, 4);
    tries = 0;
    do begin
      cycle(1, 0, 0, 0);
      tries++;
    end while (!(last_exp.clk && !last_exp.tick) && tries < 20);
    check("hi_phase_found", last_exp.clk, 1);
    @(posedge in_clk);
    #2;
    check("pre_rst_out_clk", out_clk, 1);
    in_rst_n = 1'b0;
    #1;
    check("async_rst_out_clk",  out_clk,  0);
    check("async_rst_out_tick", out_tick, 0);
    check("async_rst_cur_div",  cur_div,  4);
    check("async_rst_busy",     div_busy, 0);
    @(negedge in_clk);
    enable   = 1'b0;
    div_load = 1'b0;
    model_reset();
    in_rst_n = 1'b1;
    repeat (10) cycle(1, 0, 0, 0);

    repeat (3) @(posedge in_clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
Runtime-programmable successor to the fixed clock divider. It derives a registered, glitch-free divided clock `out_clk` and a one-cycle period-start strobe `out_tick` from `in_clk`. Two divide modes are supported: linear (divide by N) and power-of-two (divide by 2^k). Divisor changes apply only at period boundaries, so no runt pulses occur. Feeds the processor core clock and peripheral tick enables.

Parameters:
CNT_W, 16, width of the divisor and the phase counter; legal divisors are 2..2^CNT_W-1
DEFAULT_DIV, 4, divisor in effect after reset; must be within 2..2^CNT_W-1

Ports:
in_clk  input  1  system clock; all logic is on its rising edge
in_rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = run; 0 = hold the output low and re-phase
div_mode  input  1  0 = linear (D = div_value); 1 = power (D = 2^div_value[4:0])
div_value  input  CNT_W  requested divisor or exponent
div_load  input  1  one-cycle request; captures div_mode and div_value
div_busy  output  1  a captured request is pending and not yet applied
cur_div  output  CNT_W  effective divisor D currently in use
cfg_err  output  1  sticky flag: the last applied request was clamped
out_clk  output  1  divided clock, registered
out_tick  output  1  high for one in_clk cycle at each out_clk period start

Behaviour:
- Reset (asynchronous, in_rst_n=0), applied immediately:
  - phase p=0, running=0
  - cur_div=DEFAULT_DIV
  - out_clk=0, out_tick=0, div_busy=0, cfg_err=0
  - pending register cleared
- Clamp rules, evaluated at capture:
  - linear: div_value 0 or 1 -> D=2, err=1.
  - power: exp=div_value[4:0]. exp=0 -> D=2, err=1. exp>CNT_W-1 -> D=2^(CNT_W-1), err=1. Otherwise D=2^exp, err=0.
- Phase counter, on each rising edge with enable=1:
  - p_next = 0 if running=0 or p=D-1; otherwise p+1.
  - running <= 1.
- Outputs are registered from p_next:
  - H = (D+1)>>1, i.e. out_clk high for ceil(D/2) cycles.
  - out_clk <= (p_next < H).
  - out_tick <= (p_next == 0).
  - Odd D: high phase is one cycle longer (e.g. D=5 gives 1,1,1,0,0).
- First enabled edge after reset or after re-enable: out_clk=1 and out_tick=1 on that edge, with no extra latency.
- enable=0 at an edge: p<=0, running<=0, out_clk<=0, out_tick<=0. The counter resumes phase-aligned at the next enabled edge.
- Load handshake:
  - div_load=1 at an edge captures the clamped D and err into pending; div_busy<=1.
  - Pending is applied at the first later edge where p_next==0 (wrap or restart). At that edge: cur_div<=pending D, cfg_err<=pending err, div_busy<=0. The new D also governs that edge's H and all following cycles.
  - If enable=0, pending is applied at the next edge.
- Simultaneous and overlapping events:
  - div_load while div_busy=1: pending is overwritten (last request wins); div_busy stays 1.
  - div_load on the same edge as a wrap: the previously pending value (if any) is applied. The new request becomes pending for the next boundary.
- cfg_err clears only on reset or on application of a non-clamped request.
- Mid-period reset: all outputs go low asynchronously; no partial pulse is produced.

Decomposition:
- Package clkdiv_pkg holds:
  - the mode constants MODE_LIN=0 and MODE_POW=1
  - the default CNT_W
  - the pure function clamp_div(mode, value) -> {D, err}
- One sub-module, clkdiv_cfg_reg, holds the capture, clamp, pending and apply logic. It outputs cur_div, cfg_err and div_busy. Its inputs are an apply strobe (p_next==0) plus the load ports.
- The top level keeps the phase counter and the output registers.

Test Plan:
- Reset release, enable=1, no load -> out_clk 1,1,0,0 repeating; out_tick every 4th cycle, coincident with out_clk rising; cur_div=4.
- div_load linear 5 at p=1 -> div_busy=1 for 3 cycles; at the wrap cur_div=5 and the pattern becomes 1,1,1,0,0; busy drops at that edge.
- div_load power with exponent 3 -> D=8, pattern 4 high / 4 low, cfg_err=0. Then power with exponent 20 (CNT_W=16) -> cur_div=32768, cfg_err=1.
- Linear div_value=1 -> cur_div=2, out_clk toggles every cycle, cfg_err=1. A following load of 6 clears cfg_err at its apply edge.
- Two loads (7, then 9) before one wrap -> only 9 is applied; div_busy high throughout. A load on the wrap edge itself is applied at the following wrap.
- enable dropped mid-period -> out_clk=0 and out_tick=0 at the next edge. Re-enable -> out_tick=1 on the first edge. in_rst_n pulsed mid-high-phase -> out_clk drops without waiting for a clock edge.
